down_counter: RTL and testbench

Loadable down-counter: the counterpart to the free-running up-counter in the word-frequency datapath. It accepts a 16-bit start value over a valid/ready load handshake. It decrements once per enabled cycle down to zero, then signals completion with a single-cycle pulse. Downstream logic uses it to drain or replay a previously accumulated count, for example to emit one word per tick until a frequency bucket is exhausted.

---
 rtl/counter_pkg.sv | 12 +
 rtl/down_counter.sv | 71 +++++++
 tb/tb_down_counter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the word-frequency counters.
package counter_pkg;

  localparam int COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter: accepts a start value, decrements on enable to zero,
// then pulses done for one cycle before returning to idle.
//
// state | meaning
// IDLE  | waiting for a load; load_ready high
// COUNT | decrementing on enable; leaves once the count is zero
// DONE  | one-cycle completion pulse, count held at zero
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_dat,
  output logic             load_ready,
  output logic [WIDTH-1:0] dat_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          cnt_nxt   = load_dat;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        // Zero check comes first so the decrement can never wrap.
        if (cnt == '0) begin
          state_nxt = DONE;
        end else if (enable) begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign load_ready = (state == IDLE) && !reset;
  assign dat_out    = cnt;
  assign zero       = (cnt == '0);
  assign busy       = (state == COUNT) || (state == DONE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_down_counter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         load_valid;
  logic [W-1:0] load_dat;
  logic         load_ready;
  logic [W-1:0] dat_out;
  logic         zero;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  // model: value being drained, whether a drain is in progress, whether the
  // completion cycle is showing
  int m_val  = 0;
  bit m_run  = 1'b0;
  bit m_fin  = 1'b0;

  down_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_dat   (load_dat),
    .load_ready (load_ready),
    .dat_out    (dat_out),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_val = 0;
      m_run = 1'b0;
      m_fin = 1'b0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_run) begin
      if (m_val == 0) begin
        m_run = 1'b0;
        m_fin = 1'b1;
      end else if (enable) begin
        m_val = m_val - 1;
      end
    end else if (load_valid) begin
      m_val = int'(load_dat);
      m_run = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_dat_out",    32'(dat_out),    32'(m_val));
      check("model_zero",       32'(zero),       32'(m_val == 0));
      check("model_busy",       32'(busy),       32'(m_run || m_fin));
      check("model_done",       32'(done),       32'(m_fin));
      check("model_load_ready", 32'(load_ready), 32'(!m_run && !m_fin && !reset));
    end
  end

  task automatic load(input logic [W-1:0] v);
    load_valid = 1'b1;
    load_dat   = v;
    tick();
    load_valid = 1'b0;
  endtask

  int exp3[6];
  int en3[5];
  bit saw_ffff;

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_dat   = '0;
    tick();
    cmp_on = 1'b1;
    tick();
    @(negedge clk);
    check("rst_dat_out", 32'(dat_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_load_ready_low", 32'(load_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_load_ready", 32'(load_ready), 32'd1);
    tick();

    // load 5, enable held high
    enable = 1'b1;
    load(16'd5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("l5_seq", 32'(dat_out), 32'(5 - i));
      check("l5_no_done", 32'(done), 32'd0);
      tick();
    end
    @(negedge clk);
    check("l5_done", 32'(done), 32'd1);
    check("l5_done_dat", 32'(dat_out), 32'd0);
    tick();
    @(negedge clk);
    check("l5_done_width", 32'(done), 32'd0);
    check("l5_ready_after", 32'(load_ready), 32'd1);
    tick();

    // load 3 with stalls
    exp3 = '{3, 2, 2, 1, 1, 0};
    en3  = '{1, 0, 1, 0, 1};
    load(16'd3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("l3_seq", 32'(dat_out), 32'(exp3[k]));
      check("l3_no_done", 32'(done), 32'd0);
      if (k < 5) enable = en3[k][0];
      tick();
    end
    @(negedge clk);
    check("l3_done", 32'(done), 32'd1);
    tick();
    @(negedge clk);
    check("l3_done_width", 32'(done), 32'd0);
    enable = 1'b1;
    tick();

    // load 0
    load(16'd0);
    @(negedge clk);
    check("l0_busy", 32'(busy), 32'd1);
    check("l0_no_done", 32'(done), 32'd0);
    check("l0_dat", 32'(dat_out), 32'd0);
    tick();
    @(negedge clk);
    check("l0_done", 32'(done), 32'd1);
    check("l0_dat2", 32'(dat_out), 32'd0);
    tick();
    @(negedge clk);
    check("l0_idle", 32'(load_ready), 32'd1);
    tick();

    // load 4, then hold load_valid with 7 throughout
    load(16'd4);
    load_valid = 1'b1;
    load_dat   = 16'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_seq", 32'(dat_out), 32'(4 - i));
      check("hold_not_ready", 32'(load_ready), 32'd0);
      tick();
    end
    @(negedge clk);
    check("hold_done", 32'(done), 32'd1);
    check("hold_done_dat", 32'(dat_out), 32'd0);
    tick();
    @(negedge clk);
    check("hold_idle_dat", 32'(dat_out), 32'd0);
    check("hold_idle_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    @(negedge clk);
    check("hold_reload", 32'(dat_out), 32'd7);
    check("hold_reload_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 12; i++) tick();

    // full-range load aborted by reset
    load(16'hFFFF);
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("ffff_after10", 32'(dat_out), 32'hFFF5);
    reset = 1'b1;
    #1;
    check("ffff_rst_ready_low", 32'(load_ready), 32'd0);
    tick();
    @(negedge clk);
    check("ffff_rst_dat", 32'(dat_out), 32'd0);
    check("ffff_rst_busy", 32'(busy), 32'd0);
    check("ffff_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    #1;
    check("ffff_ready_after", 32'(load_ready), 32'd1);
    tick();
    @(negedge clk);
    check("ffff_no_done", 32'(done), 32'd0);

    // load 1, must not underflow
    saw_ffff = 1'b0;
    load(16'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dat_out == 16'hFFFF) saw_ffff = 1'b1;
      if (i == 0) check("l1_first", 32'(dat_out), 32'd1);
      if (i == 1) check("l1_second", 32'(dat_out), 32'd0);
      if (i == 2) check("l1_done", 32'(done), 32'd1);
      tick();
    end
    check("l1_no_underflow", 32'(saw_ffff), 32'd0);

    // randomized traffic; the per-cycle compare does the checking
    for (int c = 0; c < 3000; c++) begin
      enable     = ($urandom_range(0, 3) != 0);
      load_valid = ($urandom_range(0, 2) == 0);
      load_dat   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
